anabellek_yanitlayici: RTL and testbench

- Responder (slave) end of the iomem valid/ready bus driven by the main-memory controller; this block serves the other side of that bus.
- Serves word requests from an on-chip SRAM array in the 0x40xx_xxxx region.
- Serves a read-only 64-bit free-running timer at TIMER_BASE, with a programmable wait-state count.
- Any unmapped address gets an error response.

---
 rtl/anabellek_yanitlayici.sv | 139 +++++++++++++
 tb/tb_anabellek_yanitlayici.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_yanitlayici.sv
// Responder side of the iomem valid/ready bus: on-chip SRAM window, a read-only
// 64-bit free-running timer with a coherent high-word snapshot, and error replies.
module anabellek_yanitlayici #(
  parameter int unsigned DEPTH_LOG2  = 17,
  parameter logic [7:0]  MEM_BASE    = 8'h40,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] TIMER_BASE  = 32'h3000_0000,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        err_o
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_GAP} state_e;
  typedef enum logic [1:0] {RG_SRAM, RG_TIMER, RG_NONE} region_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  region_e     region_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [63:0] timer_q;
  logic [31:0] snap_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  function automatic region_e decode(input logic [31:0] a);
    if (a[31:24] == MEM_BASE && (a[23:0] >> (DEPTH_LOG2 + 2)) == 24'd0) return RG_SRAM;
    if (a[31:3] == TIMER_BASE[31:3]) return RG_TIMER;
    return RG_NONE;
  endfunction

  // With zero wait states the response is formed on the accepting edge, so the
  // live bus is used in IDLE and the latched copy everywhere else.
  logic                  in_idle, accept, enter_resp;
  logic [31:0]           req_addr, req_wdata;
  logic [3:0]            req_wstrb;
  region_e               req_region;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           mem_word, merged, resp_data;
  logic                  unused_addr;

  assign in_idle     = (state_q == ST_IDLE);
  assign accept      = in_idle && iomem_valid;
  assign req_addr    = in_idle ? iomem_addr  : addr_q;
  assign req_wdata   = in_idle ? iomem_wdata : wdata_q;
  assign req_wstrb   = in_idle ? iomem_wstrb : wstrb_q;
  assign req_region  = in_idle ? decode(iomem_addr) : region_q;
  assign word_idx    = req_addr[DEPTH_LOG2+1:2];
  assign mem_word    = mem[word_idx];
  assign enter_resp  = (state_d == ST_RESP);
  assign unused_addr = ^req_addr[1:0];

  assign iomem_ready = (state_q == ST_RESP);
  assign err_o       = (state_q == ST_RESP) && err_q;

  // NOTE: every signal written in an always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (iomem_valid) state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd1) state_d = ST_RESP;
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    merged = mem_word;
    for (int k = 0; k < 4; k++) begin
      if (req_wstrb[k]) merged[8*k +: 8] = req_wdata[8*k +: 8];
    end
  end

  always_comb begin
    resp_data = ERR_DATA;
    unique case (req_region)
      RG_SRAM:  resp_data = merged;
      RG_TIMER: resp_data = req_addr[2] ? snap_q : timer_q[31:0];
      default:  resp_data = ERR_DATA;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      region_q    <= RG_NONE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      timer_q     <= 64'd0;
      snap_q      <= 32'd0;
      err_q       <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_q + 64'd1;
      if (accept) begin
        addr_q   <= iomem_addr;
        wdata_q  <= iomem_wdata;
        wstrb_q  <= iomem_wstrb;
        region_q <= decode(iomem_addr);
        cnt_q    <= WAIT_LD;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_resp) begin
        iomem_rdata <= resp_data;
        err_q       <= (req_region == RG_NONE);
        // Low-word read freezes the high word so a following high read is coherent.
        if (req_region == RG_TIMER && req_wstrb == 4'd0 && !req_addr[2])
          snap_q <= timer_q[63:32];
      end
    end
  end

  // NOTE: the SRAM array has no reset; clearing it would need a multi-cycle
  // sweep, and the reset only has to discard the in-flight write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && req_region == RG_SRAM && req_wstrb != 4'd0)
      mem[word_idx] <= merged;
  end

endmodule

// File: tb/tb_anabellek_yanitlayici.sv
// Directed bench: a transaction-level model (scheduling, word store, cycles since
// reset) is compared against the DUT every cycle, plus literal expectations.
module tb_anabellek_yanitlayici;
  localparam int          W        = 2;
  localparam logic [31:0] T_BASE   = 32'h3000_0000;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ready, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  anabellek_yanitlayici dut (
    .clk_i(clk), .rst_ni(rst_n), .iomem_valid(valid), .iomem_ready(ready),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata),
    .iomem_rdata(rdata), .err_o(err)
  );

  int n_checks = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          cyc = 0, rst_edge = 0, free_edge = 0, pend_cyc = 0, resp_cyc = -1;
  bit          pend = 0, exp_known = 1, exp_err = 0, timer_known = 1, chk_on = 0;
  logic [31:0] pa, pd, exp_rdata = 32'd0, m_snap = 32'd0;
  logic [3:0]  ps;
  logic [31:0] mm [int];

  task automatic complete();
    int          idx;
    logic [31:0] old, mrg;
    bit          known;
    longint unsigned t;
    idx = int'(pa[18:2]);
    if (pa[31:24] == 8'h40 && pa[23:19] == 5'd0) begin
      known = mm.exists(idx);
      old   = known ? mm[idx] : 32'd0;
      for (int k = 0; k < 4; k++) mrg[8*k +: 8] = ps[k] ? pd[8*k +: 8] : old[8*k +: 8];
      known = known || (ps == 4'hF);
      if (ps != 4'd0) begin
        if (known) mm[idx] = mrg;
        else mm.delete(idx);
      end
      exp_rdata = mrg; exp_known = known; exp_err = 0;
    end else if (pa[31:3] == T_BASE[31:3]) begin
      exp_err = 0;
      if (ps != 4'd0 || !timer_known) exp_known = 0;
      else if (!pa[2]) begin
        t = longint'(cyc - rst_edge - 1);
        exp_rdata = t[31:0]; m_snap = t[63:32]; exp_known = 1;
      end else begin
        exp_rdata = m_snap; exp_known = 1;
      end
    end else begin
      exp_rdata = ERR_WORD; exp_err = 1; exp_known = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      rst_edge = cyc; pend = 0; free_edge = cyc + 1;
      exp_rdata = 32'd0; exp_known = 1; exp_err = 0; m_snap = 32'd0; timer_known = 1;
    end else begin
      if (valid && cyc >= free_edge) begin
        pend = 1; pend_cyc = cyc + W; free_edge = cyc + W + 3;
        pa = addr; ps = wstrb; pd = wdata;
      end
      if (pend && cyc == pend_cyc) begin
        pend = 0; resp_cyc = cyc; complete();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("ready", {31'd0, ready}, {31'd0, resp_cyc == cyc});
      check("err", {31'd0, err}, {31'd0, (resp_cyc == cyc) && exp_err});
      if (exp_known) check("rdata", rdata, exp_rdata);
    end
  end

  // Drives a request from the current negedge and holds it until ready.
  task automatic do_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int start;
    bit got;
    start = cyc; got = 0; rd = 32'd0; er = 1'b0; lat = -1;
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1; rd = rdata; er = err; lat = cyc - start;
      end
    end
    valid = 1'b0;
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL timeout: no ready for addr %h", a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nrdy;

    repeat (3) @(negedge clk);
    chk_on = 1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(32'h4000_0010, 4'hF, 32'h1234_5678, rd, er, lat);
    check("wr_latency", lat, 32'd3);
    check("wr_err", {31'd0, er}, 32'd0);
    do_req(32'h4000_0010, 4'h0, 32'd0, rd, er, lat);
    check("rd_full", rd, 32'h1234_5678);

    do_req(32'h4000_0010, 4'b0101, 32'hAABB_CCDD, rd, er, lat);
    check("wr_strb_rdata", rd, 32'h12BB_56DD);
    do_req(32'h4000_0010, 4'h0, 32'd0, rd, er, lat);
    check("rd_strb", rd, 32'h12BB_56DD);

    do_req(32'h4000_0000, 4'hF, 32'h0BAD_F00D, rd, er, lat);
    do_req(32'h4000_0020, 4'hF, 32'hCAFE_F00D, rd, er, lat);
    do_req(32'h5000_0000, 4'hF, 32'h0000_0001, rd, er, lat);
    check("unmap_wr_err", {31'd0, er}, 32'd1);
    check("unmap_wr_rdata", rd, ERR_WORD);
    do_req(32'h4000_0000, 4'h0, 32'd0, rd, er, lat);
    check("word0_intact", rd, 32'h0BAD_F00D);
    do_req(32'h4008_0000, 4'h0, 32'd0, rd, er, lat);
    check("oor_rd_err", {31'd0, er}, 32'd1);
    check("oor_rd_rdata", rd, ERR_WORD);
    do_req(32'h4000_0010, 4'h0, 32'd0, rd, er, lat);
    check("word4_intact", rd, 32'h12BB_56DD);

    do_req(T_BASE, 4'h0, 32'd0, rd, er, lat);
    do_req(T_BASE + 32'd4, 4'h0, 32'd0, rd, er, lat);
    check("tmr_hi_early", rd, 32'd0);
    do_req(T_BASE, 4'hF, 32'hFFFF_FFFF, rd, er, lat);
    check("tmr_wr_err", {31'd0, er}, 32'd0);

    // valid held high: one response per W+3 cycles, never adjacent
    repeat (2) @(negedge clk);
    valid = 1'b1; addr = 32'h4000_0010; wstrb = 4'h0; nrdy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ready === 1'b1) nrdy++;
    end
    valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ready === 1'b1) nrdy++;
    end
    check("b2b_count", nrdy, 32'd3);

    // valid dropped after acceptance: latched request still completes
    valid = 1'b1; addr = 32'h4000_0000; wstrb = 4'h0; nrdy = 0;
    @(negedge clk);
    valid = 1'b0; addr = 32'h5000_0000;
    repeat (8) begin
      @(negedge clk);
      if (ready === 1'b1) nrdy++;
    end
    check("drop_valid_count", nrdy, 32'd1);
    check("drop_valid_rdata", rdata, 32'h0BAD_F00D);

    // reset during WAIT of a write
    valid = 1'b1; addr = 32'h4000_0020; wstrb = 4'hF; wdata = 32'h1111_2222;
    @(negedge clk);
    valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    do_req(T_BASE, 4'h0, 32'd0, rd, er, lat);
    check("tmr_restart", rd, 32'd2);
    check("tmr_latency", lat, 32'd3);
    do_req(32'h4000_0020, 4'h0, 32'd0, rd, er, lat);
    check("aborted_wr", rd, 32'hCAFE_F00D);

    // timer low/high coherence across the 32-bit carry
    repeat (2) @(negedge clk);
    timer_known = 0;
    force dut.timer_q = 64'h0000_0000_FFFF_FFFC;
    @(negedge clk);
    release dut.timer_q;
    do_req(T_BASE, 4'h0, 32'd0, rd, er, lat);
    check("carry_lo", {rd[31:1], 1'b0}, 32'hFFFF_FFFE);
    do_req(T_BASE + 32'd4, 4'h0, 32'd0, rd, er, lat);
    check("carry_hi_snap", rd, 32'd0);
    do_req(T_BASE, 4'h0, 32'd0, rd, er, lat);
    do_req(T_BASE + 32'd4, 4'h0, 32'd0, rd, er, lat);
    check("post_carry_hi", rd, 32'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
